cache_req_arbiter: RTL and testbench
====================================

# cache_req_arbiter

Round-robin arbiter that shares the single read port of `cache_controller` among `NUM_REQ` address-stream requesters, for example instruction and data trace streams. It grants one requester at a time and drives `addr`/`rd_en` into the cache. It samples `hit_flag` after a fixed latency, returns a tagged hit/miss response to the owning requester, and keeps per-requester hit/miss statistics so the bench can report a hit ratio per stream, not only an aggregate.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; legal range 1..8.
- `ADDR_WIDTH`, 32: address width; matches the cache.
- `HIT_LAT`, 1: cycles from the cycle `cache_rd_en` is high to the cycle `cache_hit_flag` is valid; must be ≥1.
- `CNT_WIDTH`, 32: width of each statistics counter.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — reset, synchronous and active-low (`rst==0` at a rising `clk` edge resets).
- `req_valid`  in  NUM_REQ  — requester i has an address pending.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  — flat; slice i is `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_ready`  out  NUM_REQ  — one-hot accept; transfer occurs when `req_valid[i] && req_ready[i]`.
- `cache_addr`  out  ADDR_WIDTH  — address to the cache.
- `cache_rd_en`  out  1  — one-cycle access strobe.
- `cache_hit_flag`  in  1  — cache hit indication.
- `rsp_valid`  out  1  — one-cycle response pulse.
- `rsp_id`  out  $clog2(NUM_REQ) (min 1)  — requester index of the response.
- `rsp_hit`  out  1  — 1 = hit, 0 = miss.
- `hit_cnt`  out  NUM_REQ*CNT_WIDTH  — per-requester hit counts, flat.
- `miss_cnt`  out  NUM_REQ*CNT_WIDTH  — per-requester miss counts, flat.
- `busy`  out  1  — high whenever the FSM is not in IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP. Only one access is outstanding at a time.
- **IDLE:**
  - The grant is the first requester with `req_valid` set, searching from `rr_ptr` upward and wrapping at `NUM_REQ-1` to 0.
  - `req_ready` is combinational and equals the one-hot grant while in IDLE; it is 0 in every other state.
  - On a transfer, latch the address and id, set `rr_ptr` to grant+1 (mod `NUM_REQ`), and go to ISSUE.
  - With no request pending, stay in IDLE and leave `rr_ptr` unchanged.
- **ISSUE:**
  - `cache_rd_en` = 1 and `cache_addr` = the latched address.
  - Go to WAIT if `HIT_LAT` > 1, otherwise go to RESP.
- **WAIT:** a down-counter runs `HIT_LAT`-1 cycles, then the FSM goes to RESP.
- **RESP:**
  - Sample `cache_hit_flag` and pulse `rsp_valid` with `rsp_id`/`rsp_hit`.
  - Increment `hit_cnt[id]` or `miss_cnt[id]`.
  - Go to IDLE.
- `cache_addr` holds its value from ISSUE until the next ISSUE; it is not cleared between accesses.
- Counters saturate at all-ones; they never wrap.
- A requester that deasserts `req_valid` in IDLE without a transfer is legal and loses no state.
- Requester inputs are ignored outside IDLE.
- `NUM_REQ`=1 degenerates to a pass-through sequencer; `rr_ptr` stays at 0.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `req_ready` 0, `cache_rd_en` 0, `cache_addr` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_hit` 0, all counters 0, `busy` 0.
- With a transfer at edge t:
  - ISSUE occupies cycle t+1.
  - RESP occupies cycle t+1+`HIT_LAT`.
  - The next grant is possible in cycle t+2+`HIT_LAT`.
  - Throughput is one access per `HIT_LAT`+2 cycles under continuous requests.
- Counter updates are visible in the cycle after the `rsp_valid` pulse.
- Reset asserted mid-access (ISSUE, WAIT or RESP):
  - The in-flight access is dropped with no response.
  - Counters clear to 0.
  - The FSM returns to IDLE on the same edge.
- Simultaneous requests from all requesters are served in strict rotation; no requester waits more than `NUM_REQ`-1 grants.

## Configuration
- Macro: `CACHE_REQ_ARB_STATS_EN`.
- **Defined:** the `hit_cnt`/`miss_cnt` registers and their saturation logic are built.
- **Undefined:**
  - `hit_cnt` and `miss_cnt` are tied to 0.
  - No counter flops are built.
  - Responses and arbitration are unchanged.

## Structure
- The shared package `cache_sim_pkg` holds:
  - the FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - the default `ADDR_WIDTH`/`CNT_WIDTH` constants;
  - a function computing `rsp_id` width as max(1, clog2(`NUM_REQ`)).
- Sub-module `rr_pick`: purely combinational round-robin picker. Inputs are the `req_valid` vector and `rr_ptr`; outputs are a one-hot grant and its index.
- The FSM, latches and counters live in `cache_req_arbiter`.

## Test plan
- **Reset values:** hold reset low for 3 cycles while `req_valid`=2'b11 → all outputs at their reset values, no `req_ready`, `busy`=0.
- **Single requester:** `req_valid`=2'b01, addr 0x100, `HIT_LAT`=1, cache model reports a miss → `cache_rd_en` at t+1 with `cache_addr`=0x100; at t+2 `rsp_valid`=1, `rsp_id`=0, `rsp_hit`=0; `miss_cnt[0]`=1.
- **Contention:** both requesters valid for 6 grants from reset → grant order 0,1,0,1,0,1; each response carries the correct id; grants are spaced 3 cycles apart.
- **Latency sweep:** `HIT_LAT`=3, repeat the same address twice → first response is a miss, second is a hit; each RESP occurs 4 cycles after its transfer; `hit_cnt[0]`=1, `miss_cnt[0]`=1.
- **Reset mid-access:** reset pulled low during WAIT → no `rsp_valid`, counters read 0, FSM back in IDLE on the next cycle, and the next request is granted normally.
- **Saturation** (`CNT_WIDTH`=4, stats enabled): 17 hits on requester 1 → `hit_cnt[1]`=15 and it holds there. With the macro undefined, the same run gives counters = 0.

Source files
------------

// File: rtl/cache_sim_pkg.sv
// Shared types and constants for the cache simulation blocks: FSM encoding,
// default widths and the response-id width helper.
package cache_sim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 32;

    // A single requester still needs a 1-bit id field.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cache_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr,
// wrapping to 0, as a one-hot grant plus its index.
module rr_pick
    import cache_sim_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               any
);

    int j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (!any && req_valid[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin share of the cache read port with tagged hit/miss responses and
// optional per-requester statistics (built when CACHE_REQ_ARB_STATS_EN is defined).
module cache_req_arbiter
    import cache_sim_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int HIT_LAT    = 1,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    localparam int IDW       = id_width(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [ADDR_WIDTH-1:0]           cache_addr,
    output logic                            cache_rd_en,
    input  logic                            cache_hit_flag,
    output logic                            rsp_valid,
    output logic [IDW-1:0]                  rsp_id,
    output logic                            rsp_hit,
    output logic [NUM_REQ*CNT_WIDTH-1:0]    hit_cnt,
    output logic [NUM_REQ*CNT_WIDTH-1:0]    miss_cnt,
    output logic                            busy
);

    // WAIT lasts HIT_LAT-1 cycles: load HIT_LAT-2 and exit on zero.
    localparam int WLOAD = (HIT_LAT > 1) ? HIT_LAT - 2 : 0;
    localparam int WCW   = (HIT_LAT > 2) ? $clog2(HIT_LAT - 1) : 1;

    arb_state_e state, state_nxt;

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_a;
    logic [NUM_REQ-1:0]                 pick_gnt;
    logic [IDW-1:0]                     pick_idx;
    logic                               pick_any;
    logic [IDW-1:0]                     rr_ptr;
    logic [IDW-1:0]                     id_q;
    logic [ADDR_WIDTH-1:0]              addr_q;
    logic [WCW-1:0]                     wait_cnt;
    logic                               xfer;
    logic                               rsp_fire;

    assign addr_a = req_addr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_gnt),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    assign xfer     = rst && (state == IDLE) && pick_any;
    assign rsp_fire = rst && (state == RESP);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Outputs are gated by rst so a reset edge never sees a handshake or response.
    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        cache_rd_en = 1'b0;
        rsp_valid   = 1'b0;
        rsp_id      = '0;
        rsp_hit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_any) state_nxt = ISSUE;
                if (rst)      req_ready = pick_gnt;
            end
            ISSUE: begin
                state_nxt   = (HIT_LAT > 1) ? WAIT : RESP;
                cache_rd_en = rst;
            end
            WAIT: begin
                if (wait_cnt == '0) state_nxt = RESP;
            end
            RESP: begin
                state_nxt = IDLE;
                if (rst) begin
                    rsp_valid = 1'b1;
                    rsp_id    = id_q;
                    rsp_hit   = cache_hit_flag;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr   <= '0;
            id_q     <= '0;
            addr_q   <= '0;
            wait_cnt <= '0;
        end else begin
            if (xfer) begin
                addr_q <= addr_a[pick_idx];
                id_q   <= pick_idx;
                rr_ptr <= (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end
            if (state == ISSUE)
                wait_cnt <= WCW'(WLOAD);
            else if (state == WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - 1'b1;
        end
    end

    assign cache_addr = addr_q;
    assign busy       = (state != IDLE);

`ifdef CACHE_REQ_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_WIDTH-1:0] hit_a, miss_a;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [CNT_WIDTH-1:0] h_q, m_q;

        // Saturating counters: stop at all-ones rather than wrap.
        always_ff @(posedge clk) begin
            if (!rst) begin
                h_q <= '0;
                m_q <= '0;
            end else if (rsp_fire && id_q == IDW'(i)) begin
                if (cache_hit_flag && h_q != '1)  h_q <= h_q + 1'b1;
                if (!cache_hit_flag && m_q != '1) m_q <= m_q + 1'b1;
            end
        end

        assign hit_a[i]  = h_q;
        assign miss_a[i] = m_q;
    end

    assign hit_cnt  = hit_a;
    assign miss_cnt = miss_a;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cache_req_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int ADDR_WIDTH = 32;
    localparam int HIT_LAT    = 3;
    localparam int CNT_WIDTH  = 4;
    localparam int IDW        = 1;
    localparam int CMAX       = (1 << CNT_WIDTH) - 1;
`ifdef CACHE_REQ_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                          clk = 1'b0;
    logic                          rst = 1'b0;
    logic [NUM_REQ-1:0]            req_valid = '0;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]            req_ready;
    logic [ADDR_WIDTH-1:0]         cache_addr;
    logic                          cache_rd_en;
    logic                          cache_hit_flag = 1'b0;
    logic                          rsp_valid;
    logic [IDW-1:0]                rsp_id;
    logic                          rsp_hit;
    logic [NUM_REQ*CNT_WIDTH-1:0]  hit_cnt;
    logic [NUM_REQ*CNT_WIDTH-1:0]  miss_cnt;
    logic                          busy;

    always #5 clk = ~clk;

    cache_req_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (ADDR_WIDTH),
        .HIT_LAT    (HIT_LAT),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .cache_addr     (cache_addr),
        .cache_rd_en    (cache_rd_en),
        .cache_hit_flag (cache_hit_flag),
        .rsp_valid      (rsp_valid),
        .rsp_id         (rsp_id),
        .rsp_hit        (rsp_hit),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt),
        .busy           (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: idle, or k cycles into an access (k=1 is the cache strobe).
    bit                  m_busy = 1'b0;
    int                  m_k    = 0;
    int                  m_id   = 0;
    int                  m_ptr  = 0;
    logic [ADDR_WIDTH-1:0] m_caddr = '0;
    bit                  m_hit  = 1'b0;
    int                  hit_target = -1;
    int                  m_hc[NUM_REQ];
    int                  m_mc[NUM_REQ];
    bit                  seen[logic [ADDR_WIDTH-1:0]];

    // Observed DUT events.
    int g_cyc[$];
    int g_id[$];
    int r_cyc[$];
    int r_id[$];
    bit r_hit[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) if (v[k]) return k;
        return -1;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] cnt_of(input logic [NUM_REQ*CNT_WIDTH-1:0] v, input int i);
        return v[i*CNT_WIDTH +: CNT_WIDTH];
    endfunction

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            m_hc[i] = 0;
            m_mc[i] = 0;
        end
        forever begin
            int pk;
            bit rv;
            logic [NUM_REQ-1:0] er;
            @(negedge clk);
            pk = (rst && !m_busy) ? pick(req_valid, m_ptr) : -1;
            if (cyc > 0) begin
                er = '0;
                if (pk >= 0) er[pk] = 1'b1;
                rv = rst && m_busy && (m_k == 1 + HIT_LAT);
                chk("req_ready", req_ready, er);
                chk("busy", busy, m_busy);
                chk("cache_rd_en", cache_rd_en, rst && m_busy && (m_k == 1));
                chk("cache_addr", cache_addr, m_caddr);
                chk("rsp_valid", rsp_valid, rv);
                chk("rsp_id", rsp_id, rv ? m_id : 0);
                chk("rsp_hit", rsp_hit, rv ? m_hit : 1'b0);
                for (int i = 0; i < NUM_REQ; i++) begin
                    chk("hit_cnt", cnt_of(hit_cnt, i), STATS ? m_hc[i] : 0);
                    chk("miss_cnt", cnt_of(miss_cnt, i), STATS ? m_mc[i] : 0);
                end
                if ((req_valid & req_ready) != '0) begin
                    g_cyc.push_back(cyc);
                    g_id.push_back(onehot_idx(req_valid & req_ready));
                end
                if (rsp_valid === 1'b1) begin
                    r_cyc.push_back(cyc);
                    r_id.push_back(int'(rsp_id));
                    r_hit.push_back(rsp_hit);
                end
            end
            // Advance the model to what the coming edge produces.
            if (!rst) begin
                m_busy  = 1'b0;
                m_ptr   = 0;
                m_caddr = '0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    m_hc[i] = 0;
                    m_mc[i] = 0;
                end
            end else if (!m_busy) begin
                if (pk >= 0) begin
                    m_busy  = 1'b1;
                    m_k     = 1;
                    m_id    = pk;
                    m_caddr = req_addr[pk*ADDR_WIDTH +: ADDR_WIDTH];
                    m_ptr   = (pk + 1) % NUM_REQ;
                end
            end else begin
                if (m_k == 1) begin
                    m_hit = seen.exists(m_caddr);
                    seen[m_caddr] = 1'b1;
                    hit_target = cyc + HIT_LAT;
                end
                if (m_k == 1 + HIT_LAT) begin
                    if (m_hit) m_hc[m_id] = (m_hc[m_id] < CMAX) ? m_hc[m_id] + 1 : CMAX;
                    else       m_mc[m_id] = (m_mc[m_id] < CMAX) ? m_mc[m_id] + 1 : CMAX;
                    m_busy = 1'b0;
                end
                m_k++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        cache_hit_flag = (cyc == hit_target) ? m_hit : 1'($urandom);
    endtask

    task automatic clear_logs();
        g_cyc.delete(); g_id.delete();
        r_cyc.delete(); r_id.delete(); r_hit.delete();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) tick();
        rst = 1'b1;
        clear_logs();
    endtask

    task automatic wait_grant(input int n, input int budget);
        int b = 0;
        while (g_id.size() < n && b < budget) begin tick(); b++; end
        chk("grant_timeout", g_id.size() >= n, 1'b1);
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int b = 0;
        while (r_id.size() < n && b < budget) begin tick(); b++; end
        chk("rsp_timeout", r_id.size() >= n, 1'b1);
    endtask

    task automatic set_addr(input int i, input logic [ADDR_WIDTH-1:0] a);
        req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = a;
    endtask

    initial begin
        // Reset held with both requesters asking.
        rst = 1'b0;
        req_valid = 2'b11;
        set_addr(0, 32'h50); set_addr(1, 32'h54);
        repeat (3) tick();
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_en", cache_rd_en, 1'b0);
        chk("rst_addr", cache_addr, 32'h0);
        chk("rst_rsp", {rsp_valid, rsp_id, rsp_hit}, 3'b000);
        chk("rst_cnt", {hit_cnt, miss_cnt}, 16'h0);
        req_valid = '0;
        rst = 1'b1;

        // Single requester, first access to 0x100 misses.
        do_reset(1);
        req_valid = 2'b01; set_addr(0, 32'h100);
        wait_grant(1, 20);
        req_valid = '0;
        chk("single_rd_en", cache_rd_en, 1'b1);
        chk("single_addr", cache_addr, 32'h100);
        wait_rsp(1, 20);
        if (r_id.size() >= 1 && g_id.size() >= 1) begin
            chk("single_lat", r_cyc[0] - g_cyc[0], 1 + HIT_LAT);
            chk("single_id", r_id[0], 0);
            chk("single_hit", r_hit[0], 1'b0);
        end
        chk("single_miss_cnt", cnt_of(miss_cnt, 0), STATS ? 1 : 0);

        // Contention: strict alternation, HIT_LAT+2 cycles apart.
        do_reset(1);
        req_valid = 2'b11; set_addr(0, 32'h200); set_addr(1, 32'h204);
        wait_rsp(6, 80);
        req_valid = '0;
        if (g_id.size() >= 6 && r_id.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("cont_order", g_id[i], i % 2);
                chk("cont_rsp_id", r_id[i], g_id[i]);
                if (i > 0) chk("cont_spacing", g_cyc[i] - g_cyc[i-1], HIT_LAT + 2);
            end
        end

        // Same address twice: miss then hit.
        do_reset(1);
        req_valid = 2'b01; set_addr(0, 32'h300);
        wait_rsp(2, 40);
        req_valid = '0;
        if (r_id.size() >= 2 && g_id.size() >= 2) begin
            chk("lat_hit0", r_hit[0], 1'b0);
            chk("lat_hit1", r_hit[1], 1'b1);
            chk("lat_lat0", r_cyc[0] - g_cyc[0], 1 + HIT_LAT);
            chk("lat_lat1", r_cyc[1] - g_cyc[1], 1 + HIT_LAT);
        end
        chk("lat_hit_cnt", cnt_of(hit_cnt, 0), STATS ? 1 : 0);
        chk("lat_miss_cnt", cnt_of(miss_cnt, 0), STATS ? 1 : 0);

        // Reset while waiting for the cache.
        do_reset(1);
        req_valid = 2'b01; set_addr(0, 32'h400);
        wait_grant(1, 20);
        req_valid = '0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_cnt", {hit_cnt, miss_cnt}, 16'h0);
        repeat (6) tick();
        chk("midrst_no_rsp", r_id.size(), 0);
        req_valid = 2'b01; set_addr(0, 32'h404);
        wait_rsp(1, 20);
        req_valid = '0;
        if (r_id.size() >= 1) chk("midrst_next_id", r_id[0], 0);

        // Saturation: 1 miss then 17 hits on requester 1, then one more hit.
        do_reset(1);
        req_valid = 2'b10; set_addr(1, 32'h900);
        wait_rsp(18, 18 * (HIT_LAT + 2) + 20);
        chk("sat_hit_cnt", cnt_of(hit_cnt, 1), STATS ? 15 : 0);
        chk("sat_miss_cnt", cnt_of(miss_cnt, 1), STATS ? 1 : 0);
        wait_rsp(19, 2 * (HIT_LAT + 2) + 4);
        req_valid = '0;
        tick();
        chk("sat_hold", cnt_of(hit_cnt, 1), STATS ? 15 : 0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 59) != 0);
            req_valid = NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++)
                set_addr(i, 32'h1000 + 16 * $urandom_range(0, 7));
            tick();
        end
        rst = 1'b1;
        req_valid = '0;
        repeat (HIT_LAT + 4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
